lut_sweep_ctrl: RTL and testbench



---
 rtl/lut_sweep_pkg.sv | 20 ++
 rtl/lut_vec_gen.sv | 33 +++
 rtl/lut_sweep_ctrl.sv | 118 +++++++++++
 tb/tb_lut_sweep_ctrl.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/lut_sweep_pkg.sv
// Shared types and constants for the LUT4 sweep controller.
package lut_sweep_pkg;
    localparam int MAX_IN = 4;
    localparam int TT_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_CHECK,
        ST_DONE
    } state_e;

    function automatic logic [3:0] lowest_set(input logic [TT_W-1:0] v);
        lowest_set = '0;
        for (int i = TT_W - 1; i >= 0; i--) begin
            if (v[i]) lowest_set = 4'(i);
        end
    endfunction
endpackage

// File: rtl/lut_vec_gen.sv
// Sweep index counter and applied-vector generator.
// LUT_SWEEP_GRAY_EN selects Gray-code vector order.
module lut_vec_gen #(
    parameter int N_IN = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clear,
    input  logic            advance,
    output logic [N_IN-1:0] vec,
    output logic            last
);
    logic [N_IN-1:0] idx_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q <= '0;
        end else if (clear) begin
            idx_q <= '0;
        end else if (advance) begin
            idx_q <= idx_q + N_IN'(1);
        end
    end

    // Terminal flag tracks the index, not the vector, so Gray order ends on time
    assign last = &idx_q;

`ifdef LUT_SWEEP_GRAY_EN
    assign vec = idx_q ^ (idx_q >> 1);
`else
    assign vec = idx_q;
`endif
endmodule

// File: rtl/lut_sweep_ctrl.sv
// Configures one LUT4, sweeps its inputs and checks the responses.
// Optional LUT_SWEEP_GRAY_EN applies vectors in Gray-code order.
module lut_sweep_ctrl #(
    parameter int N_IN   = 2,
    parameter int SETTLE = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cfg_valid,
    output logic        cfg_ready,
    input  logic [15:0] cfg_init,
    input  logic [15:0] cfg_expect,
    input  logic        start,
    output logic [15:0] lut_cfg,
    output logic [3:0]  lut_in,
    input  logic        lut_out,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] result,
    output logic [3:0]  fail_idx
);
    import lut_sweep_pkg::*;

    localparam int NV = 1 << N_IN;
    localparam logic [TT_W-1:0] MASK = TT_W'((33'h1 << NV) - 33'h1);
    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [SW-1:0] SC_LAST = SW'((SETTLE > 0) ? SETTLE - 1 : 0);
    localparam state_e FIRST = (SETTLE == 0) ? ST_SAMPLE : ST_SETTLE;

    state_e          state_q;
    logic [SW-1:0]   sc_q;
    logic            cfg_ready_q, busy_q, done_q, pass_q, loaded_q;
    logic [TT_W-1:0] lut_cfg_q, expect_q, result_q, diff_d;
    logic [3:0]      fail_idx_q;
    logic [N_IN-1:0] vec;
    logic            last, idle_ph, cfg_acc, start_acc, advance, drive;

    assign idle_ph   = (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign cfg_acc   = idle_ph && cfg_valid;
    assign start_acc = idle_ph && !cfg_valid && start && loaded_q;
    assign advance   = (state_q == ST_SAMPLE) && !last;
    assign drive     = (state_q == ST_SETTLE) || (state_q == ST_SAMPLE);
    assign diff_d    = (result_q ^ expect_q) & MASK;

    lut_vec_gen #(.N_IN(N_IN)) u_vec (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (start_acc),
        .advance (advance),
        .vec     (vec),
        .last    (last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            sc_q        <= '0;
            cfg_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            loaded_q    <= 1'b0;
            lut_cfg_q   <= '0;
            expect_q    <= '0;
            result_q    <= '0;
            fail_idx_q  <= '0;
        end else begin
            unique case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (cfg_acc) begin
                        lut_cfg_q <= cfg_init;
                        expect_q  <= cfg_expect;
                        loaded_q  <= 1'b1;
                        done_q    <= 1'b0;
                        pass_q    <= 1'b0;
                        state_q   <= ST_IDLE;
                    end else if (start_acc) begin
                        state_q     <= FIRST;
                        sc_q        <= '0;
                        result_q    <= '0;
                        busy_q      <= 1'b1;
                        cfg_ready_q <= 1'b0;
                        done_q      <= 1'b0;
                        pass_q      <= 1'b0;
                    end
                end
                ST_SETTLE: begin
                    if (sc_q == SC_LAST) state_q <= ST_SAMPLE;
                    else sc_q <= sc_q + SW'(1);
                end
                ST_SAMPLE: begin
                    result_q[vec] <= lut_out;
                    sc_q          <= '0;
                    state_q       <= last ? ST_CHECK : FIRST;
                end
                ST_CHECK: begin
                    pass_q      <= (diff_d == '0);
                    fail_idx_q  <= lowest_set(diff_d);
                    busy_q      <= 1'b0;
                    done_q      <= 1'b1;
                    cfg_ready_q <= 1'b1;
                    state_q     <= ST_DONE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign cfg_ready = cfg_ready_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign lut_cfg   = lut_cfg_q;
    assign result    = result_q;
    assign fail_idx  = fail_idx_q;
    assign lut_in    = drive ? MAX_IN'(vec) : '0;
endmodule

// File: tb/tb_lut_sweep_ctrl.sv
// Self-checking bench: 2-input/SETTLE=1 and 4-input/SETTLE=0 controllers.
module tb_lut_sweep_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        cfg_valid, cfg_ready, start, lut_out;
    logic        busy, done, pass;
    logic [15:0] cfg_init, cfg_expect, lut_cfg, result;
    logic [3:0]  lut_in, fail_idx;
    logic        frc_en;
    logic [3:0]  frc_vec;

    logic        c4_valid, c4_ready, c4_start, c4_out;
    logic        c4_busy, c4_done, c4_pass;
    logic [15:0] c4_init, c4_expect, c4_cfg, c4_result;
    logic [3:0]  c4_in, c4_fidx;

    // LUT behavioural model with an optional stuck-at-1 on one vector
    assign lut_out = (frc_en && lut_in == frc_vec) ? 1'b1 : lut_cfg[lut_in];
    assign c4_out  = c4_cfg[c4_in];

    lut_sweep_ctrl #(.N_IN(2), .SETTLE(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_init(cfg_init), .cfg_expect(cfg_expect),
        .start(start), .lut_cfg(lut_cfg), .lut_in(lut_in),
        .lut_out(lut_out), .busy(busy), .done(done), .pass(pass),
        .result(result), .fail_idx(fail_idx)
    );

    lut_sweep_ctrl #(.N_IN(4), .SETTLE(0)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .cfg_valid(c4_valid), .cfg_ready(c4_ready),
        .cfg_init(c4_init), .cfg_expect(c4_expect),
        .start(c4_start), .lut_cfg(c4_cfg), .lut_in(c4_in),
        .lut_out(c4_out), .busy(c4_busy), .done(c4_done), .pass(c4_pass),
        .result(c4_result), .fail_idx(c4_fidx)
    );

    typedef struct {
        logic [15:0] init;
        logic [15:0] expv;
        logic        fen;
        logic [3:0]  fvec;
        logic [15:0] res;
        logic        ps;
        logic [3:0]  fi;
    } rec_t;

    typedef struct {
        logic [15:0] res;
        logic        ps;
        logic [3:0]  fi;
        int          lat;
    } exp_t;

    rec_t tbl[7];
    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] gvec(input int i);
`ifdef LUT_SWEEP_GRAY_EN
        return 4'(i ^ (i >> 1));
`else
        return 4'(i);
`endif
    endfunction

    task automatic sweep2(input rec_t r);
        exp_t e;
        int   k;
        @(negedge clk);
        cfg_valid = 1'b1; cfg_init = r.init; cfg_expect = r.expv;
        frc_en = r.fen; frc_vec = r.fvec;
        @(negedge clk);
        cfg_valid = 1'b0;
        chk("cfg_clears_done", {done, pass}, 0);
        start = 1'b1;
        e.res = r.res; e.ps = r.ps; e.fi = r.fi; e.lat = 9;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (k < 100 && !done) begin
            if (k < 8) chk("lut_in_seq", lut_in, gvec(k / 2));
            @(negedge clk);
            k++;
        end
        e = sb.pop_front();
        chk("done_seen", done, 1);
        chk("latency", k, e.lat);
        chk("result", result, e.res);
        chk("pass", pass, e.ps);
        chk("fail_idx", fail_idx, e.fi);
        chk("lut_in_done", lut_in, 0);
        chk("lut_cfg", lut_cfg, r.init);
    endtask

    initial begin
        exp_t e;
        int   k;
        tbl[0] = '{16'h8888, 16'h0008, 1'b0, 4'd0, 16'h0008, 1'b1, 4'd0};
        tbl[1] = '{16'h8888, 16'h0008, 1'b1, 4'd1, 16'h000A, 1'b0, 4'd1};
        tbl[2] = '{16'hEEEE, 16'h000E, 1'b0, 4'd0, 16'h000E, 1'b1, 4'd0};
        tbl[3] = '{16'h7777, 16'h0008, 1'b0, 4'd0, 16'h0007, 1'b0, 4'd0};
        tbl[4] = '{16'h8888, 16'h0000, 1'b0, 4'd0, 16'h0008, 1'b0, 4'd3};
        tbl[5] = '{16'h8888, 16'hFFF8, 1'b0, 4'd0, 16'h0008, 1'b1, 4'd0};
        tbl[6] = '{16'h6666, 16'h0008, 1'b0, 4'd0, 16'h0006, 1'b0, 4'd1};

        rst_n = 1'b0;
        cfg_valid = 0; cfg_init = 0; cfg_expect = 0; start = 0;
        frc_en = 0; frc_vec = 0;
        c4_valid = 0; c4_init = 0; c4_expect = 0; c4_start = 0;
        repeat (2) @(negedge clk);
        chk("reset2", {cfg_ready, busy, done, pass, lut_cfg, lut_in,
                       result, fail_idx}, {4'b1000, 40'h0});
        chk("reset4", {c4_ready, c4_busy, c4_done, c4_pass, c4_cfg,
                       c4_in, c4_result, c4_fidx}, {4'b1000, 40'h0});
        rst_n = 1'b1;

        // start before any configuration
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (2) @(negedge clk);
        chk("nocfg_start", {busy, done, cfg_ready}, 3'b001);

        // simultaneous cfg and start: config only
        @(negedge clk);
        cfg_valid = 1'b1; start = 1'b1; cfg_init = 16'h8888;
        @(negedge clk);
        cfg_valid = 1'b0; start = 1'b0;
        chk("simul_cfg", lut_cfg, 16'h8888);
        repeat (2) @(negedge clk);
        chk("simul_nosweep", {busy, done}, 2'b00);

        for (int i = 0; i < 7; i++) sweep2(tbl[i]);

        // asynchronous reset during vector 2
        @(negedge clk);
        cfg_valid = 1'b1; cfg_init = 16'h8888; cfg_expect = 16'h0008;
        frc_en = 1'b0;
        @(negedge clk); cfg_valid = 1'b0; start = 1'b1;
        @(negedge clk); start = 1'b0;
        k = 0;
        while (k < 20 && lut_in != gvec(2)) begin
            @(negedge clk);
            k++;
        end
        chk("reached_vec2", {busy, lut_in}, {1'b1, gvec(2)});
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset", {cfg_ready, busy, done, pass, lut_cfg, lut_in,
                            result, fail_idx}, {4'b1000, 40'h0});
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (3) @(negedge clk);
        chk("start_after_rst", {busy, done}, 2'b00);

        // 4-input XOR4, SETTLE=0, with start and cfg offered while busy
        @(negedge clk);
        c4_valid = 1'b1; c4_init = 16'h6996; c4_expect = 16'h6996;
        @(negedge clk);
        c4_valid = 1'b0; c4_start = 1'b1;
        e.res = 16'h6996; e.ps = 1'b1; e.fi = 4'd0; e.lat = 17;
        sb.push_back(e);
        @(negedge clk);
        c4_start = 1'b0;
        k = 0;
        while (k < 100 && !c4_done) begin
            chk("c4_ready_busy", c4_ready, 0);
            if (k < 16) chk("c4_lut_in", c4_in, gvec(k));
            if (k == 5) c4_start = 1'b1;
            if (k == 6) c4_start = 1'b0;
            if (k == 7) begin c4_valid = 1'b1; c4_init = 16'h1234; end
            if (k == 8) c4_valid = 1'b0;
            @(negedge clk);
            k++;
        end
        e = sb.pop_front();
        chk("c4_done_seen", c4_done, 1);
        chk("c4_latency", k, e.lat);
        chk("c4_result", c4_result, e.res);
        chk("c4_pass", {c4_pass, c4_fidx}, {e.ps, e.fi});
        chk("c4_cfg_hold", c4_cfg, 16'h6996);
        repeat (2) @(negedge clk);
        chk("c4_done_held", {c4_done, c4_busy, c4_ready}, 3'b101);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
